// File: rtl/march_addr_gen_if.sv
// Handshake/control bundle between the BIST controller, the address
// sequencer and the SRAM access driver.
interface march_addr_gen_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic             descending;
  logic [WIDTH-1:0] last;
  logic             abort;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] addr;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   count;

  // Controller/consumer side: drives the sweep request and back-pressure.
  modport master (
    output start, descending, last, abort, ready,
    input  valid, addr, busy, done, count
  );

  // Sequencer side.
  modport slave (
    input  start, descending, last, abort, ready,
    output valid, addr, busy, done, count
  );
endinterface

// File: rtl/march_addr_gen.sv
// Loadable up/down address sequencer for the SRAM BIST path. Walks 0..last
// or last..0, one address per valid/ready handshake, then pulses done.
module march_addr_gen #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  march_addr_gen_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH:0]   count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             desc_q, desc_d;
  logic             final_addr;

  // The end check happens before any step, so addr never wraps at either end.
  assign final_addr = desc_q ? (addr_q == '0) : (addr_q == last_q);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    last_d  = last_q;
    desc_d  = desc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          desc_d  = bus.descending;
          last_d  = bus.last;
          addr_d  = bus.descending ? bus.last : '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins over a same-cycle handshake: nothing is counted.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.ready) begin
          count_d = count_q + (WIDTH+1)'(1);
          if (final_addr) begin
            state_d = DONE;
          end else if (desc_q) begin
            addr_d = addr_q - WIDTH'(1);
          end else begin
            addr_d = addr_q + WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      last_q  <= last_d;
      desc_q  <= desc_d;
    end
  end

  // Outputs decode straight from registers; no input-to-output path.
  assign bus.valid = (state_q == RUN);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.addr  = addr_q;
  assign bus.count = count_q;

endmodule

// File: doc/march_addr_gen.md
# march_addr_gen

Loadable up/down address sequencer for the SRAM BIST path. On `start` it walks an address range from 0 to `last` (ascending) or from `last` to 0 (descending), presenting one address per valid/ready handshake. Once the final address is consumed it pulses `done`. It sits between the BIST controller, which drives start, direction and range, and the SRAM access driver, which consumes addresses. Where the free-running counter only counts up under `en`, this block adds direction control and flow control.

## Interface
- `WIDTH`, default 12: address width in bits.
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  begin a sweep; sampled only in IDLE.
- `descending`  input  1  sweep direction, latched with `start` (1 = `last` down to 0).
- `last`  input  WIDTH  highest address of the sweep, latched with `start`.
- `abort`  input  1  terminate the sweep in progress; no `done` is produced.
- `ready`  input  1  consumer accepts `addr` this cycle.
- `valid`  output  1  `addr` is valid.
- `addr`  output  WIDTH  current address.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse after the final handshake.
- `count`  output  WIDTH+1  handshakes completed in the current or most recent sweep.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; `valid`, `busy`, `done` = 0; `addr` = 0; `count` = 0; latched direction = 0; latched `last` = 0.
- **IDLE**
  - `start`=1: latch `descending` and `last`; load `addr` with 0 (ascending) or `last` (descending); clear `count`; go to RUN.
  - `abort` is ignored in IDLE.
- **RUN**
  - `valid` = 1, `busy` = 1.
  - A handshake occurs in any cycle with `valid` && `ready`.
  - On a handshake that is not the final address: `count` += 1, and `addr` += 1 (ascending) or −= 1 (descending).
  - Final address is `last` (ascending) or 0 (descending). On its handshake: `count` += 1, go to DONE, `addr` holds.
  - `ready`=0: `addr`, `count` and state hold; `valid` stays high (no retraction).
  - `start` in RUN is ignored.
- **DONE**
  - `done` = 1, `valid` = 0, `busy` = 0.
  - Unconditionally return to IDLE next cycle; `start` is ignored in DONE.
- **Abort**: `abort`=1 in RUN goes to IDLE next cycle with `done` = 0. It takes priority over a same-cycle handshake: that handshake is not counted and `addr` does not advance. `count` holds its value.
- **Arithmetic**
  - `addr` never wraps: the final-address check precedes any increment or decrement, so `last` = all-ones ascending and 0 descending are both safe.
  - `count` is WIDTH+1 bits so a full sweep of 2^WIDTH addresses fits.
  - `last` = 0 gives a single-address sweep in either direction.
- `rst` overrides everything, including mid-sweep: next cycle is IDLE with all reset values.

## Timing
- `start` sampled at edge N: `valid`=1 with the first address from edge N (visible in cycle N+1). Latency is 1 cycle.
- With `ready` held at 1, one address per cycle. A sweep of L = `last`+1 addresses takes L cycles in RUN.
- Final handshake at edge M: `done`=1 and `valid`=0 in cycle M+1. Back in IDLE at edge M+1, so the earliest new `start` is sampled at edge M+2.
- Abort sampled at edge A: `valid`=0, `busy`=0 in cycle A+1; `done` never asserts.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst` 16 cycles with random inputs -> `valid`=0, `busy`=0, `done`=0, `addr`=0, `count`=0 throughout.
- **Ascending sweep:** `last`=15, `descending`=0, `ready`=1, pulse `start` -> `addr` 0..15 on 16 consecutive valid cycles; `done` one cycle later; `count`=16.
- **Descending with back-pressure:** `last`=7, `descending`=1, `ready` toggling 1,0,1,0… -> `addr` 7..0, each held across `ready`=0 cycles; `count`=8; exactly one `done` pulse.
- **Boundaries:**
  - `last`=0 in each direction -> single `addr`=0 beat, `count`=1.
  - `last`=4095 ascending -> final `addr`=4095, `count`=4096, no wrap to 0.
- **Abort:** `last`=15 ascending; assert `abort` together with `ready` on the 6th beat (`addr`=5) -> `count`=5, `done` never asserts, IDLE next cycle; new `start` works normally.
- **Ignored starts / mid-sweep reset:**
  - `start` during RUN and during DONE -> no effect on the sequence.
  - `rst` at `addr`=9 -> reset values next cycle.
